// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table sweep controller
package tt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FIN
  } state_t;

  localparam int N_IN_DEFAULT = 4;
  localparam int NVEC         = 1 << N_IN_DEFAULT;
  localparam int SETTLE_W     = 4;

endpackage

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - sweeps a boolean function through all input vectors and checks its truth table
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(1<<N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       f_in,
  input  logic                  f_out,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  table_out,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic [N_IN-1:0]       first_err_idx,
  output logic                  first_err_valid
);

  localparam int NV = 1 << N_IN;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [N_IN-1:0]     LAST_VEC    = {N_IN{1'b1}};
  // With no settle time every vector is sampled back-to-back from SAMPLE.
  localparam state_t VEC_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t              state;
  logic [NV-1:0]       exp_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                mismatch;

  always_comb begin
    mismatch = (f_out != exp_q[f_in]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      exp_q           <= '0;
      settle_cnt      <= '0;
      f_in            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      table_out       <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_q           <= expected;
            f_in            <= '0;
            table_out       <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            settle_cnt      <= '0;
            busy            <= 1'b1;
            state           <= VEC_ENTRY;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
            if (settle_cnt == SETTLE_LAST) begin
              state <= S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            table_out[f_in] <= f_out;
            if (mismatch) begin
              err_count <= err_count + (N_IN+1)'(1);
              if (!first_err_valid) begin
                first_err_idx   <= f_in;
                first_err_valid <= 1'b1;
              end
            end
            // pass folds in the last vector's compare, which lands on this same edge.
            if (f_in == LAST_VEC) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              f_in       <= f_in + N_IN'(1);
              settle_cnt <= '0;
              state      <= VEC_ENTRY;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - directed bench for tt_sweep_ctrl against a PoS function model
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] expected = 16'h0000;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [3:0]  f_in1;
  logic        f_out1, busy1, done1, pass1, fev1;
  logic [15:0] table1;
  logic [4:0]  ecnt1;
  logic [3:0]  fidx1;

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [3:0]  f_in0;
  logic        f_out0, busy0, done0, pass0, fev0;
  logic [15:0] table0;
  logic [4:0]  ecnt0;
  logic [3:0]  fidx0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // PoS(0,1,6,7,8,9,12,14): zero exactly on the listed maxterms.
  function automatic logic pos_model(input logic [3:0] v);
    return !(v inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd14});
  endfunction

  assign f_out1 = pos_model(f_in1);
  assign f_out0 = pos_model(f_in0);

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected),
    .f_in(f_in1), .f_out(f_out1), .busy(busy1), .done(done1), .table_out(table1),
    .pass(pass1), .err_count(ecnt1), .first_err_idx(fidx1), .first_err_valid(fev1)
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(expected),
    .f_in(f_in0), .f_out(f_out0), .busy(busy0), .done(done0), .table_out(table0),
    .pass(pass0), .err_count(ecnt0), .first_err_idx(fidx0), .first_err_valid(fev0)
  );

  typedef struct {
    logic [15:0] mask;
    logic [15:0] tbl;
    logic [4:0]  errs;
    logic [3:0]  idx;
    logic        valid;
    logic        ok;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Pulses start on u1 and returns the number of edges from the start edge to done.
  // With noise set, start is re-pulsed mid-sweep while the expected input is corrupted.
  task automatic sweep1(input logic noise, output int lat);
    logic [15:0] keep;
    keep = expected;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin
      if (noise && (lat == 3 || lat == 10)) begin
        start1 = 1'b1; expected = 16'h0000;
      end else begin
        start1 = 1'b0; expected = keep;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0; expected = keep;
  endtask

  task automatic wait_fin1(input logic [3:0] v, output logic hit);
    int n;
    n = 0;
    while (f_in1 != v && n < 200) begin
      @(negedge clk); n++;
    end
    hit = (f_in1 == v);
  endtask

  initial begin
    int lat;
    int dones;
    logic hit;

    vecs[0] = '{16'hAC3C, 16'hAC3C, 5'd0,  4'd0,  1'b0, 1'b1};
    vecs[1] = '{16'hAC3D, 16'hAC3C, 5'd1,  4'd0,  1'b1, 1'b0};
    vecs[2] = '{16'h53C3, 16'hAC3C, 5'd16, 4'd0,  1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'hAC3C, 5'd8,  4'd2,  1'b1, 1'b0};
    vecs[4] = '{16'hAC3E, 16'hAC3C, 5'd1,  4'd1,  1'b1, 1'b0};
    vecs[5] = '{16'h2C3C, 16'hAC3C, 5'd1,  4'd15, 1'b1, 1'b0};

    #12;
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset f_in", f_in1, 0);
    chk("reset table", table1, 0);
    chk("reset pass", pass1, 0);
    chk("reset err_count", ecnt1, 0);
    chk("reset fev", fev1, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      expected = vecs[i].mask;
      sweep1(1'b0, lat);
      chk($sformatf("v%0d latency", i), lat, 32);
      chk($sformatf("v%0d done", i), done1, 1);
      chk($sformatf("v%0d table", i), table1, vecs[i].tbl);
      chk($sformatf("v%0d err_count", i), ecnt1, vecs[i].errs);
      chk($sformatf("v%0d first_idx", i), fidx1, vecs[i].idx);
      chk($sformatf("v%0d first_valid", i), fev1, vecs[i].valid);
      chk($sformatf("v%0d pass", i), pass1, vecs[i].ok);
      @(negedge clk);
      chk($sformatf("v%0d done width", i), done1, 0);
      chk($sformatf("v%0d pass hold", i), pass1, vecs[i].ok);
    end

    // Zero settle: 16-cycle sweep, start held through FIN gives one sweep then a restart.
    expected = 16'hAC3C;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done0 && lat < 200) begin
      @(negedge clk); lat++;
    end
    chk("s0 latency", lat, 16);
    chk("s0 table", table0, 16'hAC3C);
    chk("s0 pass", pass0, 1);
    @(negedge clk);
    chk("s0 idle busy", busy0, 0);
    chk("s0 idle done", done0, 0);
    @(negedge clk);
    chk("s0 restart busy", busy0, 1);
    chk("s0 restart f_in", f_in0, 0);
    start0 = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    chk("s0 second sweep dones", dones, 1);

    // Abort at f_in=5.
    expected = 16'hAC3C;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_fin1(4'd5, hit);
    chk("abort reached f_in 5", hit, 1);
    abort1 = 1'b1;
    @(negedge clk); abort1 = 1'b0;
    chk("abort busy", busy1, 0);
    chk("abort f_in", f_in1, 5);
    chk("abort table", table1, 16'h001C);
    chk("abort err_count", ecnt1, 0);
    chk("abort pass", pass1, 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    chk("abort no done", dones, 0);
    chk("abort f_in hold", f_in1, 5);
    sweep1(1'b0, lat);
    chk("post-abort latency", lat, 32);
    chk("post-abort table", table1, 16'hAC3C);
    chk("post-abort pass", pass1, 1);

    // Asynchronous reset mid-sweep at f_in=9.
    expected = 16'hAC3D;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_fin1(4'd9, hit);
    chk("reset reached f_in 9", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst f_in", f_in1, 0);
    chk("async rst busy", busy1, 0);
    chk("async rst table", table1, 0);
    chk("async rst fev", fev1, 0);
    @(negedge clk); rst_n = 1'b1;
    sweep1(1'b1, lat);
    chk("post-rst latency", lat, 32);
    chk("post-rst table", table1, 16'hAC3C);
    chk("post-rst err_count", ecnt1, 1);
    chk("post-rst first_idx", fidx1, 0);
    chk("post-rst pass", pass1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("post-rst idle", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
